ipm_distributed_fifo_ctrl_v1_2_ip_fifo: RTL and testbench

//  Single-clock FIFO controller that drives the distributed SDPRAM write/read ports. It owns pointers,

---
 rtl/ipm_fifo_pkg.sv | 31 +++
 rtl/ipm_distributed_sdpram_v1_2_ip_fifo.sv | 30 +++
 rtl/ipm_distributed_fifo_ctrl_v1_2_ip_fifo.sv | 156 +++++++++++++++
 tb/tb_ipm_distributed_fifo_ctrl_v1_2_ip_fifo.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/ipm_fifo_pkg.sv
// Shared constants and helpers for the distributed-RAM FIFO family.
package ipm_fifo_pkg;

  localparam int MIN_ADDR_WIDTH = 4;
  localparam int MAX_ADDR_WIDTH = 10;

  // Ceiling log2, usable in constant expressions.
  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      v = v >> 1;
      r = r + 1;
    end
    return r;
  endfunction

  // Number of RAM words addressed by an ADDR_WIDTH-bit address.
  function automatic int fifo_depth(input int addr_width);
    return 1 << addr_width;
  endfunction

  // Pointers and the occupancy count carry one extra bit so that
  // "completely full" (count == DEPTH) is representable.
  function automatic int ptr_width(input int addr_width);
    return addr_width + 1;
  endfunction

endpackage

// File: rtl/ipm_distributed_sdpram_v1_2_ip_fifo.sv
// Simple dual-port distributed RAM: synchronous write, combinational read.
module ipm_distributed_sdpram_v1_2_ip_fifo
  import ipm_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4
) (
  input  logic                  wr_clk,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  localparam int DEPTH = fifo_depth(ADDR_WIDTH);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  // Write port; contents are never reset.
  always_ff @(posedge wr_clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Asynchronous read port.
  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ipm_distributed_fifo_ctrl_v1_2_ip_fifo.sv
// Single-clock FIFO controller in front of a distributed SDPRAM.
// Owns pointers, occupancy, registered flags and the read-data register,
// turning the RAM's combinational read into a 1-cycle-latency FIFO read.
//
// Handshake: a write is accepted when wr_en=1 and the registered full=0;
// a read is accepted when rd_en=1 and the registered empty=0. There is no
// back-pressure beyond the flags: rejected requests raise wr_err/rd_err for
// one cycle and are otherwise dropped. rd_valid marks the cycle in which
// rd_data holds the word of the read accepted on the previous edge.
module ipm_distributed_fifo_ctrl_v1_2_ip_fifo
  import ipm_fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 4,
  parameter int AF_LEVEL   = fifo_depth(ADDR_WIDTH) - 2,
  parameter int AE_LEVEL   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  wr_err,
  output logic                  rd_err,
  output logic                  ram_wr_en,
  output logic [ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [DATA_WIDTH-1:0] ram_wr_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_addr,
  input  logic [DATA_WIDTH-1:0] ram_rd_data
);

  localparam int PW = ptr_width(ADDR_WIDTH);
  localparam int DEPTH = fifo_depth(ADDR_WIDTH);
  localparam logic [PW-1:0] DEPTH_CNT = PW'(DEPTH);
  localparam logic [PW-1:0] AF_CNT    = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_CNT    = PW'(AE_LEVEL);
  localparam logic [PW-1:0] ONE_CNT   = PW'(1);

  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [PW-1:0]         count_q;
  logic [PW-1:0]         count_nxt;
  logic                  full_q;
  logic                  empty_q;
  logic                  af_q;
  logic                  ae_q;
  logic                  wr_err_q;
  logic                  rd_err_q;
  logic                  rd_valid_q;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  wr_acc;
  logic                  rd_acc;

  // Acceptance uses only the registered flags, so a simultaneous read never
  // frees room for a write at full, nor a write feeds a read at empty.
  // A synchronous flush drops both requests.
  assign wr_acc = wr_en & ~full_q  & ~clr;
  assign rd_acc = rd_en & ~empty_q & ~clr;

  // Single-step occupancy update.
  always_comb begin
    count_nxt = count_q;
    unique case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + ONE_CNT;
      2'b01:   count_nxt = count_q - ONE_CNT;
      default: count_nxt = count_q;
    endcase
  end

  // Write and read pointers; the MSB toggles on each wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (clr) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_acc) wr_ptr <= wr_ptr + ONE_CNT;
      if (rd_acc) rd_ptr <= rd_ptr + ONE_CNT;
    end
  end

  // Occupancy and flags, all registered from the next count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else if (clr) begin
      count_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      af_q    <= 1'b0;
      ae_q    <= 1'b1;
    end else begin
      count_q <= count_nxt;
      full_q  <= (count_nxt == DEPTH_CNT);
      empty_q <= (count_nxt == '0);
      af_q    <= (count_nxt >= AF_CNT);
      ae_q    <= (count_nxt <= AE_CNT);
    end
  end

  // One-cycle error pulses for rejected requests; a flush suppresses them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else if (clr) begin
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      wr_err_q <= wr_en & full_q;
      rd_err_q <= rd_en & empty_q;
    end
  end

  // Read-data register: captures the RAM word on an accepted read and
  // holds it otherwise (including across a flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_acc;
      if (rd_acc) rd_data_q <= ram_rd_data;
    end
  end

  assign ram_wr_en    = wr_acc;
  assign ram_wr_addr  = wr_ptr[ADDR_WIDTH-1:0];
  assign ram_wr_data  = wr_data;
  assign ram_rd_addr  = rd_ptr[ADDR_WIDTH-1:0];

  assign rd_data      = rd_data_q;
  assign rd_valid     = rd_valid_q;
  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign count        = count_q;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_ipm_distributed_fifo_ctrl_v1_2_ip_fifo.sv
// Bench for the FIFO controller paired with a real distributed SDPRAM.
module tb_ipm_distributed_fifo_ctrl_v1_2_ip_fifo;

  localparam int AW    = 4;
  localparam int DW    = 8;
  localparam int DEPTH = 16;
  localparam int AF    = 14;
  localparam int AE    = 2;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clr = 1'b0;
  logic          wr_en = 1'b0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] wr_data = '0;
  logic [DW-1:0] rd_data;
  logic          rd_valid, full, empty, almost_full, almost_empty;
  logic [AW:0]   count;
  logic          wr_err, rd_err;
  logic          ram_wr_en;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [DW-1:0] ram_wr_data, ram_rd_data;

  always #5 clk = ~clk;

  ipm_distributed_fifo_ctrl_v1_2_ip_fifo #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .clr(clr),
    .wr_en(wr_en), .wr_data(wr_data), .rd_en(rd_en),
    .rd_data(rd_data), .rd_valid(rd_valid),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .wr_err(wr_err), .rd_err(rd_err),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_wr_data(ram_wr_data),
    .ram_rd_addr(ram_rd_addr), .ram_rd_data(ram_rd_data)
  );

  ipm_distributed_sdpram_v1_2_ip_fifo #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u_ram (
    .wr_clk(clk), .wr_en(ram_wr_en), .wr_addr(ram_wr_addr), .wr_data(ram_wr_data),
    .rd_addr(ram_rd_addr), .rd_data(ram_rd_data)
  );

  // ---------------- reference model / scoreboard ----------------
  logic [DW-1:0] model_q[$];   // words stored in the FIFO
  logic [DW-1:0] exp_q[$];     // words the DUT must present on rd_valid
  logic [DW-1:0] exp_rd_data = '0;
  bit            exp_rd_valid = 1'b0;
  bit            exp_wr_err = 1'b0;
  bit            exp_rd_err = 1'b0;
  int            tests = 0;
  int            fails = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_status();
    int cnt;
    cnt = model_q.size();
    chk("count", 32'(count), 32'(cnt));
    chk("full", 32'(full), 32'(cnt == DEPTH));
    chk("empty", 32'(empty), 32'(cnt == 0));
    chk("almost_full", 32'(almost_full), 32'(cnt >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(cnt <= AE));
    chk("wr_err", 32'(wr_err), 32'(exp_wr_err));
    chk("rd_err", 32'(rd_err), 32'(exp_rd_err));
    chk("rd_valid", 32'(rd_valid), 32'(exp_rd_valid));
    chk("rd_data_hold", 32'(rd_data), 32'(exp_rd_data));
  endtask

  // ---------------- driver ----------------
  // Drives one cycle of stimulus, advances the model at the edge and checks
  // the registered status on the following falling edge.
  task automatic cycle(input bit we, input logic [DW-1:0] wd, input bit re, input bit cl);
    int cnt;
    bit wacc, racc;
    wr_en = we; wr_data = wd; rd_en = re; clr = cl;
    @(posedge clk);
    cnt = model_q.size();
    if (cl) begin
      model_q.delete();
      exp_wr_err = 1'b0; exp_rd_err = 1'b0; exp_rd_valid = 1'b0;
    end else begin
      wacc = we && (cnt < DEPTH);
      racc = re && (cnt > 0);
      exp_wr_err = we && (cnt == DEPTH);
      exp_rd_err = re && (cnt == 0);
      exp_rd_valid = racc;
      if (racc) begin
        exp_rd_data = model_q.pop_front();
        exp_q.push_back(exp_rd_data);
      end
      if (wacc) model_q.push_back(wd);
    end
    @(negedge clk);
    check_status();
    wr_en = 1'b0; rd_en = 1'b0; clr = 1'b0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (!rst && rd_valid) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected: rd_valid with data 0x%0h, no read outstanding", rd_data);
      end else begin
        chk("sb_rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    repeat (2) @(negedge clk);
    check_status();                       // reset values
    rst = 1'b0;

    // 1. fill with 0x01..0x10, then one rejected write
    for (int i = 1; i <= DEPTH; i++) cycle(1'b1, DW'(i), 1'b0, 1'b0);
    cycle(1'b1, 8'hEE, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    // 2. drain all 16, then one rejected read
    for (int i = 0; i < DEPTH; i++) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 3. simultaneous read/write at count=5 for 40 cycles
    for (int i = 0; i < 5; i++) cycle(1'b1, DW'(8'h20 + i), 1'b0, 1'b0);
    for (int i = 0; i < 40; i++) cycle(1'b1, DW'(8'h40 + i), 1'b1, 1'b0);

    // 4. both requests at full, then at empty
    while (model_q.size() < DEPTH) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'hC3, 1'b1, 1'b0);
    while (model_q.size() > 0) cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b1, 8'h3C, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // 5. flush at count=7 with a concurrent write, then 0xAA round trip
    for (int i = 0; i < 7; i++) cycle(1'b1, DW'($urandom), 1'b0, 1'b0);
    cycle(1'b1, 8'h77, 1'b0, 1'b1);
    cycle(1'b1, 8'hAA, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);

    // random traffic with occasional flushes
    for (int i = 0; i < 400; i++)
      cycle(1'($urandom_range(0, 1)), DW'($urandom), 1'($urandom_range(0, 1)),
            ($urandom_range(0, 49) == 0));

    // 6. asynchronous reset in the middle of a burst
    for (int i = 0; i < 6; i++) cycle(1'b1, DW'($urandom), (i > 2), 1'b0);
    wr_en = 1'b1; rd_en = 1'b1; wr_data = 8'h99;
    #2 rst = 1'b1;
    #1;
    chk("arst_count", 32'(count), 32'd0);
    chk("arst_empty", 32'(empty), 32'd1);
    chk("arst_almost_empty", 32'(almost_empty), 32'd1);
    chk("arst_full", 32'(full), 32'd0);
    chk("arst_almost_full", 32'(almost_full), 32'd0);
    chk("arst_rd_valid", 32'(rd_valid), 32'd0);
    chk("arst_rd_data", 32'(rd_data), 32'd0);
    chk("arst_errs", 32'({wr_err, rd_err}), 32'd0);
    model_q.delete();
    exp_q.delete();
    exp_rd_data = '0; exp_rd_valid = 1'b0; exp_wr_err = 1'b0; exp_rd_err = 1'b0;
    wr_en = 1'b0; rd_en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b1, 8'h55, 1'b0, 1'b0);
    cycle(1'b0, 8'h00, 1'b1, 1'b0);
    cycle(1'b0, 8'h00, 1'b0, 1'b0);

    chk("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
